// File: rtl/axi_llc_tag_lookup_ctrl_if.sv
// ---------------------------------------------------------------------------
// axi_llc_tag_lookup_ctrl_if
// Purpose : bundles every non-clock/reset signal of the LLC tag lookup issue
//           stage (way masks, descriptor, tag-store request/response, result
//           stream and counters). The _i/_o suffixes are named from the
//           controller's point of view.
// Modports: slave  - the lookup controller
//           master - the environment around it (upstream, tag store, miss path)
// ---------------------------------------------------------------------------
interface axi_llc_tag_lookup_ctrl_if #(
  parameter int NumWays    = 8,
  parameter int IndexWidth = 10,
  parameter int TagWidth   = 20,
  parameter int IdWidth    = 4,
  parameter int CntWidth   = 32
);
  localparam int WayWidth = $clog2(NumWays);

  // way configuration
  logic [NumWays-1:0]    spm_lock_i;
  logic [NumWays-1:0]    flushed_i;
  // descriptor input
  logic                  desc_valid_i;
  logic                  desc_ready_o;
  logic                  desc_mode_i;
  logic [IdWidth-1:0]    desc_id_i;
  logic [IndexWidth-1:0] desc_index_i;
  logic [TagWidth-1:0]   desc_tag_i;
  logic                  desc_dirty_i;
  logic [WayWidth-1:0]   desc_way_i;
  // tag-store request
  logic                  store_valid_o;
  logic                  store_ready_i;
  logic                  store_mode_o;
  logic [NumWays-1:0]    store_indicator_o;
  logic [IndexWidth-1:0] store_index_o;
  logic [TagWidth-1:0]   store_tag_o;
  logic                  store_dirty_o;
  // tag-store response
  logic                  res_valid_i;
  logic                  res_ready_o;
  logic                  res_hit_i;
  logic                  res_evict_i;
  logic [NumWays-1:0]    res_indicator_i;
  logic [TagWidth-1:0]   res_evict_tag_i;
  // result stream
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [IdWidth-1:0]    out_id_o;
  logic                  out_mode_o;
  logic                  out_hit_o;
  logic                  out_evict_o;
  logic                  out_bypass_o;
  logic [NumWays-1:0]    out_indicator_o;
  logic [TagWidth-1:0]   out_evict_tag_o;
  // statistics
  logic                  cnt_clear_i;
  logic [CntWidth-1:0]   hit_cnt_o;
  logic [CntWidth-1:0]   miss_cnt_o;

  modport slave (
    input  spm_lock_i, flushed_i,
    input  desc_valid_i, desc_mode_i, desc_id_i, desc_index_i, desc_tag_i, desc_dirty_i, desc_way_i,
    output desc_ready_o,
    output store_valid_o, store_mode_o, store_indicator_o, store_index_o, store_tag_o, store_dirty_o,
    input  store_ready_i,
    input  res_valid_i, res_hit_i, res_evict_i, res_indicator_i, res_evict_tag_i,
    output res_ready_o,
    output out_valid_o, out_id_o, out_mode_o, out_hit_o, out_evict_o, out_bypass_o,
    output out_indicator_o, out_evict_tag_o,
    input  out_ready_i,
    input  cnt_clear_i,
    output hit_cnt_o, miss_cnt_o
  );

  modport master (
    output spm_lock_i, flushed_i,
    output desc_valid_i, desc_mode_i, desc_id_i, desc_index_i, desc_tag_i, desc_dirty_i, desc_way_i,
    input  desc_ready_o,
    input  store_valid_o, store_mode_o, store_indicator_o, store_index_o, store_tag_o, store_dirty_o,
    output store_ready_i,
    output res_valid_i, res_hit_i, res_evict_i, res_indicator_i, res_evict_tag_i,
    input  res_ready_o,
    input  out_valid_o, out_id_o, out_mode_o, out_hit_o, out_evict_o, out_bypass_o,
    input  out_indicator_o, out_evict_tag_o,
    output out_ready_i,
    output cnt_clear_i,
    input  hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/axi_llc_tag_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// axi_llc_tag_lookup_ctrl
// Purpose : issue stage in front of the LLC tag store. Accepts lookup/flush
//           descriptors, builds the tag-store request (masking SPM-locked and
//           flushed ways for lookups), records every accepted descriptor in an
//           in-order pending FIFO and joins the FIFO head with tag-store
//           responses into a single ordered result stream. Lookups with no
//           eligible way never reach the tag store but still hold their slot
//           in the result order. Saturating hit/miss counters track lookups.
// Ports   : clk_i - clock (rising edge)
//           rst_i - asynchronous active-high reset
//           bus   - axi_llc_tag_lookup_ctrl_if.slave (descriptor in, store
//                   request out, store response in, result out, counters)
// ---------------------------------------------------------------------------
module axi_llc_tag_lookup_ctrl #(
  parameter int NumWays    = 8,
  parameter int IndexWidth = 10,
  parameter int TagWidth   = 20,
  parameter int IdWidth    = 4,
  parameter int Depth      = 2,
  parameter int CntWidth   = 32
) (
  input logic                     clk_i,
  input logic                     rst_i,
  axi_llc_tag_lookup_ctrl_if.slave bus
);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntFifoW = $clog2(Depth + 1);

  // pending FIFO storage (data needs no reset, only pointers/count do)
  logic [IdWidth-1:0]  r_fifo_id     [Depth];
  logic                r_fifo_mode   [Depth];
  logic                r_fifo_bypass [Depth];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntFifoW-1:0] r_count;

  // store request register
  logic                  r_store_valid;
  logic                  r_store_mode;
  logic [NumWays-1:0]    r_store_indicator;
  logic [IndexWidth-1:0] r_store_index;
  logic [TagWidth-1:0]   r_store_tag;
  logic                  r_store_dirty;

  logic [CntWidth-1:0] r_hit_cnt;
  logic [CntWidth-1:0] r_miss_cnt;

  logic [NumWays-1:0] w_lookup_mask;
  logic [NumWays-1:0] w_indicator;
  logic               w_bypass;
  logic               w_store_free;
  logic               w_desc_ready;
  logic               w_accept;
  logic               w_empty;
  logic               w_head_mode;
  logic               w_head_bypass;
  logic [IdWidth-1:0] w_head_id;
  logic               w_out_valid;
  logic               w_pop;
  logic               w_data_en;
  logic               w_cnt_evt;
  logic               w_hit_inc;
  logic               w_miss_inc;

  // ---------------------------------------------------------------- issue
  assign w_lookup_mask = ~bus.spm_lock_i & ~bus.flushed_i;
  assign w_indicator   = bus.desc_mode_i ? (NumWays'(1) << bus.desc_way_i) : w_lookup_mask;
  assign w_bypass      = ~bus.desc_mode_i & (w_lookup_mask == '0);
  assign w_store_free  = ~r_store_valid | bus.store_ready_i;

  // A full FIFO can still accept when its head leaves in the same cycle.
  assign w_desc_ready = ((r_count < CntFifoW'(Depth)) | w_pop) & (w_bypass | w_store_free);
  assign w_accept     = bus.desc_valid_i & w_desc_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_store_valid     <= 1'b0;
      r_store_mode      <= 1'b0;
      r_store_indicator <= '0;
      r_store_index     <= '0;
      r_store_tag       <= '0;
      r_store_dirty     <= 1'b0;
    end else if (w_accept && !w_bypass) begin
      r_store_valid     <= 1'b1;
      r_store_mode      <= bus.desc_mode_i;
      r_store_indicator <= w_indicator;
      r_store_index     <= bus.desc_index_i;
      r_store_tag       <= bus.desc_tag_i;
      r_store_dirty     <= bus.desc_dirty_i;
    end else if (bus.store_ready_i) begin
      // payload is left as is; only valid drops once the store took it
      r_store_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------- pending FIFO
  assign w_empty       = (r_count == '0);
  assign w_head_id     = r_fifo_id[r_rd_ptr];
  assign w_head_mode   = r_fifo_mode[r_rd_ptr];
  assign w_head_bypass = ~w_empty & r_fifo_bypass[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_fifo_id[r_wr_ptr]     <= bus.desc_id_i;
      r_fifo_mode[r_wr_ptr]   <= bus.desc_mode_i;
      r_fifo_bypass[r_wr_ptr] <= w_bypass;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == PtrWidth'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrWidth'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ----------------------------------------------------------- result join
  // A bypass head is answered locally; otherwise the head waits for the
  // tag-store response, which always belongs to the oldest non-bypass entry.
  assign w_out_valid = ~w_empty & (w_head_bypass | bus.res_valid_i);
  assign w_pop       = w_out_valid & bus.out_ready_i;
  assign w_data_en   = w_out_valid & ~w_head_bypass;

  // ---------------------------------------------------------------- counters
  assign w_cnt_evt  = w_pop & ~w_head_mode;
  assign w_hit_inc  = w_cnt_evt & ~w_head_bypass & bus.res_hit_i;
  assign w_miss_inc = w_cnt_evt & (w_head_bypass | ~bus.res_hit_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (bus.cnt_clear_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_inc && !(&r_hit_cnt)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (w_miss_inc && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- outputs
  assign bus.desc_ready_o      = w_desc_ready;
  assign bus.store_valid_o     = r_store_valid;
  assign bus.store_mode_o      = r_store_mode;
  assign bus.store_indicator_o = r_store_indicator;
  assign bus.store_index_o     = r_store_index;
  assign bus.store_tag_o       = r_store_tag;
  assign bus.store_dirty_o     = r_store_dirty;

  assign bus.res_ready_o = bus.out_ready_i & ~w_empty & ~w_head_bypass;

  // Data fields are forced to 0 whenever they carry no meaning.
  assign bus.out_valid_o     = w_out_valid;
  assign bus.out_id_o        = w_out_valid ? w_head_id : '0;
  assign bus.out_mode_o      = w_out_valid & w_head_mode;
  assign bus.out_bypass_o    = w_out_valid & w_head_bypass;
  assign bus.out_hit_o       = w_data_en & bus.res_hit_i;
  assign bus.out_evict_o     = w_data_en & bus.res_evict_i;
  assign bus.out_indicator_o = w_data_en ? bus.res_indicator_i : '0;
  assign bus.out_evict_tag_o = (w_data_en & bus.res_evict_i) ? bus.res_evict_tag_i : '0;

  assign bus.hit_cnt_o  = r_hit_cnt;
  assign bus.miss_cnt_o = r_miss_cnt;

  // A response with nothing pending cannot be matched to any descriptor.
  a_no_res_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.res_valid_i && w_empty));
endmodule

// File: tb/tb_axi_llc_tag_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_llc_tag_lookup_ctrl
// Directed checks of the LLC tag lookup issue stage: masking, bypass, ordering,
// FIFO full/push-pop, flush, counter saturation/clear and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_axi_llc_tag_lookup_ctrl;
  localparam int NumWays    = 8;
  localparam int IndexWidth = 10;
  localparam int TagWidth   = 20;
  localparam int IdWidth    = 4;
  localparam int Depth      = 2;
  localparam int CntWidth   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi_llc_tag_lookup_ctrl_if #(
    .NumWays(NumWays), .IndexWidth(IndexWidth), .TagWidth(TagWidth),
    .IdWidth(IdWidth), .CntWidth(CntWidth)
  ) bus ();

  axi_llc_tag_lookup_ctrl #(
    .NumWays(NumWays), .IndexWidth(IndexWidth), .TagWidth(TagWidth),
    .IdWidth(IdWidth), .Depth(Depth), .CntWidth(CntWidth)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_desc(input logic valid, input logic mode, input logic [3:0] id,
                          input logic [9:0] idx, input logic [19:0] tag, input logic [2:0] way);
    bus.desc_valid_i = valid;
    bus.desc_mode_i  = mode;
    bus.desc_id_i    = id;
    bus.desc_index_i = idx;
    bus.desc_tag_i   = tag;
    bus.desc_way_i   = way;
  endtask

  task automatic set_res(input logic valid, input logic hit, input logic evict,
                         input logic [7:0] ind, input logic [19:0] etag);
    bus.res_valid_i     = valid;
    bus.res_hit_i       = hit;
    bus.res_evict_i     = evict;
    bus.res_indicator_i = ind;
    bus.res_evict_tag_i = etag;
  endtask

  // One lookup through store and response, handshaking the result.
  task automatic run_lookup(input logic [3:0] id, input logic hit, input logic clr);
    bus.spm_lock_i = '0;
    set_desc(1'b1, 1'b0, id, 10'd1, 20'h1, 3'd0);
    bus.store_ready_i = 1'b1;
    tick();
    bus.desc_valid_i = 1'b0;
    tick();
    bus.store_ready_i = 1'b0;
    set_res(1'b1, hit, 1'b0, 8'h01, 20'h0);
    bus.out_ready_i = 1'b1;
    bus.cnt_clear_i = clr;
    tick();
    set_res(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
    bus.out_ready_i = 1'b0;
    bus.cnt_clear_i = 1'b0;
  endtask

  initial begin
    bus.spm_lock_i    = '0;
    bus.flushed_i     = '0;
    bus.desc_dirty_i  = 1'b0;
    bus.store_ready_i = 1'b0;
    bus.out_ready_i   = 1'b0;
    bus.cnt_clear_i   = 1'b0;
    set_desc(1'b0, 1'b0, 4'd0, 10'd0, 20'd0, 3'd0);
    set_res(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
    repeat (3) tick();
    rst = 1'b0;
    settle();

    // reset state
    chk("rst_desc_ready", 32'(bus.desc_ready_o), 32'd1);
    chk("rst_store_valid", 32'(bus.store_valid_o), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_hit_cnt", 32'(bus.hit_cnt_o), 32'd0);
    chk("rst_miss_cnt", 32'(bus.miss_cnt_o), 32'd0);

    // 1: plain lookup, all ways eligible, hit on way 2
    set_desc(1'b1, 1'b0, 4'd3, 10'd5, 20'hABCDE, 3'd0);
    settle();
    chk("t1_desc_ready", 32'(bus.desc_ready_o), 32'd1);
    tick();
    bus.desc_valid_i = 1'b0;
    settle();
    chk("t1_store_valid", 32'(bus.store_valid_o), 32'd1);
    chk("t1_store_ind", 32'(bus.store_indicator_o), 32'hFF);
    chk("t1_store_idx", 32'(bus.store_index_o), 32'd5);
    chk("t1_store_tag", 32'(bus.store_tag_o), 32'hABCDE);
    chk("t1_out_valid_wait", 32'(bus.out_valid_o), 32'd0);
    tick();
    chk("t1_store_hold_valid", 32'(bus.store_valid_o), 32'd1);
    chk("t1_store_hold_tag", 32'(bus.store_tag_o), 32'hABCDE);
    bus.store_ready_i = 1'b1;
    tick();
    bus.store_ready_i = 1'b0;
    settle();
    chk("t1_store_drained", 32'(bus.store_valid_o), 32'd0);
    set_res(1'b1, 1'b1, 1'b0, 8'h04, 20'h55555);
    bus.out_ready_i = 1'b1;
    settle();
    chk("t1_out_valid", 32'(bus.out_valid_o), 32'd1);
    chk("t1_out_id", 32'(bus.out_id_o), 32'd3);
    chk("t1_out_hit", 32'(bus.out_hit_o), 32'd1);
    chk("t1_out_ind", 32'(bus.out_indicator_o), 32'h04);
    chk("t1_out_etag_zero", 32'(bus.out_evict_tag_o), 32'd0);
    chk("t1_res_ready", 32'(bus.res_ready_o), 32'd1);
    tick();
    set_res(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
    bus.out_ready_i = 1'b0;
    settle();
    chk("t1_hit_cnt", 32'(bus.hit_cnt_o), 32'd1);
    chk("t1_out_idle", 32'(bus.out_valid_o), 32'd0);

    // 2: all ways SPM-locked -> bypass
    bus.spm_lock_i = 8'hFF;
    set_desc(1'b1, 1'b0, 4'd7, 10'd9, 20'h00777, 3'd0);
    settle();
    chk("t2_desc_ready", 32'(bus.desc_ready_o), 32'd1);
    tick();
    bus.desc_valid_i = 1'b0;
    bus.spm_lock_i   = '0;
    settle();
    chk("t2_no_store", 32'(bus.store_valid_o), 32'd0);
    chk("t2_out_valid", 32'(bus.out_valid_o), 32'd1);
    chk("t2_out_bypass", 32'(bus.out_bypass_o), 32'd1);
    chk("t2_out_id", 32'(bus.out_id_o), 32'd7);
    chk("t2_out_hit", 32'(bus.out_hit_o), 32'd0);
    chk("t2_out_ind", 32'(bus.out_indicator_o), 32'd0);
    bus.out_ready_i = 1'b1;
    settle();
    chk("t2_res_ready_zero", 32'(bus.res_ready_o), 32'd0);
    tick();
    bus.out_ready_i = 1'b0;
    settle();
    chk("t2_miss_cnt", 32'(bus.miss_cnt_o), 32'd1);

    // 3: normal id=1 then bypass id=2 -> bypass waits behind id=1
    set_desc(1'b1, 1'b0, 4'd1, 10'd2, 20'h11111, 3'd0);
    tick();
    bus.spm_lock_i = 8'hFF;
    set_desc(1'b1, 1'b0, 4'd2, 10'd3, 20'h22222, 3'd0);
    settle();
    chk("t3_bypass_accept", 32'(bus.desc_ready_o), 32'd1);
    tick();
    bus.desc_valid_i = 1'b0;
    bus.spm_lock_i   = '0;
    bus.out_ready_i  = 1'b1;
    settle();
    chk("t3_bypass_held", 32'(bus.out_valid_o), 32'd0);
    bus.store_ready_i = 1'b1;
    tick();
    bus.store_ready_i = 1'b0;
    set_res(1'b1, 1'b0, 1'b0, 8'h10, 20'h0);
    settle();
    chk("t3_first_id", 32'(bus.out_id_o), 32'd1);
    chk("t3_first_ind", 32'(bus.out_indicator_o), 32'h10);
    tick();
    set_res(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
    settle();
    chk("t3_second_id", 32'(bus.out_id_o), 32'd2);
    chk("t3_second_bypass", 32'(bus.out_bypass_o), 32'd1);
    tick();
    bus.out_ready_i = 1'b0;
    settle();
    chk("t3_miss_cnt", 32'(bus.miss_cnt_o), 32'd3);

    // 4: FIFO fills at Depth, then push+pop while full
    bus.store_ready_i = 1'b1;
    set_desc(1'b1, 1'b0, 4'd4, 10'd4, 20'h44444, 3'd0);
    tick();
    set_desc(1'b1, 1'b0, 4'd5, 10'd5, 20'h55555, 3'd0);
    settle();
    chk("t4_second_accept", 32'(bus.desc_ready_o), 32'd1);
    tick();
    set_desc(1'b1, 1'b0, 4'd6, 10'd6, 20'h66666, 3'd0);
    settle();
    chk("t4_full_stall", 32'(bus.desc_ready_o), 32'd0);
    tick();
    bus.store_ready_i = 1'b0;
    set_res(1'b1, 1'b1, 1'b0, 8'h01, 20'h0);
    bus.out_ready_i = 1'b1;
    settle();
    chk("t4_pushpop_ready", 32'(bus.desc_ready_o), 32'd1);
    chk("t4_head_id", 32'(bus.out_id_o), 32'd4);
    tick();
    set_res(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
    bus.out_ready_i = 1'b0;
    set_desc(1'b1, 1'b0, 4'd8, 10'd8, 20'h88888, 3'd0);
    settle();
    chk("t4_still_full", 32'(bus.desc_ready_o), 32'd0);
    bus.desc_valid_i  = 1'b0;
    bus.store_ready_i = 1'b1;
    tick();
    bus.store_ready_i = 1'b0;
    set_res(1'b1, 1'b1, 1'b0, 8'h02, 20'h0);
    bus.out_ready_i = 1'b1;
    settle();
    chk("t4_order_5", 32'(bus.out_id_o), 32'd5);
    tick();
    set_res(1'b1, 1'b0, 1'b0, 8'h08, 20'h0);
    settle();
    chk("t4_order_6", 32'(bus.out_id_o), 32'd6);
    tick();
    set_res(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
    bus.out_ready_i = 1'b0;
    settle();
    chk("t4_hit_cnt", 32'(bus.hit_cnt_o), 32'd3);
    chk("t4_miss_cnt", 32'(bus.miss_cnt_o), 32'd4);

    // 5: flush way 6 ignores SPM/flushed masks; eviction data passes through
    bus.spm_lock_i = 8'h40;
    bus.flushed_i  = 8'h40;
    set_desc(1'b1, 1'b1, 4'd9, 10'd12, 20'h0, 3'd6);
    tick();
    bus.desc_valid_i = 1'b0;
    bus.spm_lock_i   = '0;
    bus.flushed_i    = '0;
    settle();
    chk("t5_store_ind", 32'(bus.store_indicator_o), 32'h40);
    chk("t5_store_mode", 32'(bus.store_mode_o), 32'd1);
    bus.store_ready_i = 1'b1;
    tick();
    bus.store_ready_i = 1'b0;
    set_res(1'b1, 1'b0, 1'b1, 8'h40, 20'h12345);
    bus.out_ready_i = 1'b1;
    settle();
    chk("t5_out_evict", 32'(bus.out_evict_o), 32'd1);
    chk("t5_out_etag", 32'(bus.out_evict_tag_o), 32'h12345);
    chk("t5_out_mode", 32'(bus.out_mode_o), 32'd1);
    tick();
    set_res(1'b0, 1'b0, 1'b0, 8'h00, 20'h0);
    bus.out_ready_i = 1'b0;
    settle();
    chk("t5_hit_unchanged", 32'(bus.hit_cnt_o), 32'd3);
    chk("t5_miss_unchanged", 32'(bus.miss_cnt_o), 32'd4);

    // 6: hit counter saturation, then clear beating a same-cycle hit
    for (int i = 0; i < 12; i++) run_lookup(4'(i), 1'b1, 1'b0);
    settle();
    chk("t6_hit_full", 32'(bus.hit_cnt_o), 32'd15);
    run_lookup(4'd13, 1'b1, 1'b0);
    settle();
    chk("t6_hit_saturated", 32'(bus.hit_cnt_o), 32'd15);
    chk("t6_miss_kept", 32'(bus.miss_cnt_o), 32'd4);
    run_lookup(4'd14, 1'b1, 1'b1);
    settle();
    chk("t6_clear_hit", 32'(bus.hit_cnt_o), 32'd0);
    chk("t6_clear_miss", 32'(bus.miss_cnt_o), 32'd0);

    // 7: reset with store busy and two entries pending
    set_desc(1'b1, 1'b0, 4'd10, 10'd10, 20'hAAAAA, 3'd0);
    tick();
    bus.spm_lock_i = 8'hFF;
    set_desc(1'b1, 1'b0, 4'd11, 10'd11, 20'hBBBBB, 3'd0);
    tick();
    bus.desc_valid_i = 1'b0;
    bus.spm_lock_i   = '0;
    settle();
    chk("t7_pre_store_valid", 32'(bus.store_valid_o), 32'd1);
    rst = 1'b1;
    settle();
    chk("t7_rst_store_valid", 32'(bus.store_valid_o), 32'd0);
    chk("t7_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("t7_desc_ready", 32'(bus.desc_ready_o), 32'd1);
    bus.spm_lock_i = 8'hFF;
    set_desc(1'b1, 1'b0, 4'd12, 10'd12, 20'hCCCCC, 3'd0);
    tick();
    bus.desc_valid_i = 1'b0;
    bus.spm_lock_i   = '0;
    settle();
    chk("t7_fifo_empty_head", 32'(bus.out_id_o), 32'd12);
    chk("t7_fifo_empty_valid", 32'(bus.out_valid_o), 32'd1);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    settle();
    chk("t7_drained", 32'(bus.out_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
